usb_tx_controller: RTL and testbench
====================================

USB_TX_CONTROLLER -- requirements
Module: usb_tx_controller

Interface
REQ-001 SHALL have parameter MAX_DATA_BYTES, default 64, max payload bytes per packet.
REQ-002 SHALL have parameter EOP_BITS, default 2, EOP duration in bit times.
REQ-003 SHALL have port clk  input  1  system clock; all state changes on the rising edge.
REQ-004 SHALL have port n_rst  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port tx_start  input  1  one-cycle packet request; sampled only in IDLE.
REQ-006 SHALL have port tx_pid  input  4  PID, sampled with tx_start.
REQ-007 SHALL have port buffer_occupancy  input  7  payload bytes available, sampled with tx_start.
REQ-008 SHALL have port tx_packet_data  input  8  current buffer head byte.
REQ-009 SHALL have port bit_strobe  input  1  one pulse per bit time, from the bit timer.
REQ-010 SHALL have port one_byte_time  input  1  byte-complete pulse from the bit timer.
REQ-011 SHALL have outputs timer_enable and timer_clear  output  1 each  bit-timer control.
REQ-012 SHALL have outputs load_en  output  1  and load_data  output  8  shift-register parallel load.
REQ-013 SHALL have output get_tx_data  output  1  one-cycle buffer pop.
REQ-014 SHALL have outputs eop, tx_busy, tx_done, tx_error  output  1 each  line EOP drive and status.

Function
REQ-015 SHALL implement the states IDLE, LOAD_SYNC, SEND_SYNC, LOAD_PID, SEND_PID, LOAD_DATA, SEND_DATA, EOP, EOP_IDLE, and the CRC states when enabled.
REQ-016 IDLE SHALL assert timer_clear=1 and timer_enable=0; every other state SHALL hold timer_clear=0.
REQ-017 On tx_start in IDLE, SHALL latch tx_pid and buffer_occupancy and go to LOAD_SYNC on the next edge, with tx_busy=1 from that cycle until IDLE is re-entered.
REQ-018 Each LOAD_* state SHALL last exactly 1 cycle, with load_en=1 and timer_enable=0; then go to the matching SEND_* state.
REQ-019 Each SEND_* state SHALL hold timer_enable=1 and SHALL exit on the cycle after one_byte_time=1.
REQ-020 load_data SHALL be:
- 8'h80 in LOAD_SYNC;
- {~pid, pid} in LOAD_PID;
- tx_packet_data in LOAD_DATA.
REQ-021 LOAD_DATA SHALL pulse get_tx_data=1 in the same cycle as load_en.
REQ-022 After SEND_PID:
- DATA0 (4'b0011) or DATA1 (4'b1011) SHALL go to LOAD_DATA while the remaining byte count is nonzero;
- every other PID SHALL go directly to EOP.
REQ-023 The remaining byte count SHALL decrement once per LOAD_DATA, SHALL be 7 bits wide, and SHALL never wrap below 0.
REQ-024 A DATA PID with latched occupancy 0 SHALL send SYNC, PID and the CRC bytes (when enabled), then EOP.
REQ-025 EOP SHALL hold eop=1 and timer_enable=1 for EOP_BITS bit_strobe pulses, then go to EOP_IDLE.
REQ-026 EOP_IDLE SHALL hold eop=0 for one bit_strobe, then pulse tx_done=1 for one cycle and return to IDLE.
REQ-027 If buffer_occupancy > MAX_DATA_BYTES at tx_start, SHALL pulse tx_error=1 for one cycle, remain in IDLE, and emit no load_en.
REQ-028 tx_start while tx_busy=1 SHALL be ignored, with no error raised.
REQ-029 one_byte_time or bit_strobe arriving in states that do not use them SHALL be ignored.
REQ-030 All outputs SHALL be registered or decoded from state only; no combinational path from inputs to outputs except load_data in LOAD_DATA.

Reset
REQ-031 n_rst=0 SHALL immediately force IDLE, clear all counters and latched PID/count, and drive:
- timer_enable, load_en, get_tx_data, eop, tx_busy, tx_done, tx_error, load_data = 0;
- timer_clear = 1.
REQ-032 Reset mid-packet SHALL abort without tx_done or tx_error; the first tx_start after release SHALL start a clean packet.

Configuration
REQ-033 With TX_CRC16_EN defined:
- SHALL add inputs crc_lo and crc_hi (8 each);
- SHALL add states LOAD_CRC1, SEND_CRC1, LOAD_CRC2, SEND_CRC2 between the last data byte and EOP for DATA PIDs;
- SHALL load crc_lo, then crc_hi.
REQ-034 Without TX_CRC16_EN, DATA packets SHALL go from the last SEND_DATA (or from SEND_PID when the count is 0) straight to EOP, and the CRC ports and states SHALL not exist.

Verification
REQ-035 ACK (tx_pid=4'b0010), occupancy 0 -> load_data 8'h80 then 8'hD2; eop high 2 bit times; tx_done one cycle; no get_tx_data.
REQ-036 DATA0 with occupancy 3, bytes 8'hA5, 8'h3C, 8'hFF -> 3 get_tx_data pulses, loads in that order, tx_done; with CRC enabled, crc_lo then crc_hi loaded before eop.
REQ-037 occupancy 65 with MAX_DATA_BYTES=64 -> tx_error one cycle, tx_busy stays 0, no load_en.
REQ-038 n_rst pulsed low during SEND_DATA byte 2 -> all outputs at reset values asynchronously; subsequent ACK packet completes normally.
REQ-039 tx_start re-pulsed during SEND_PID -> ignored; exactly one tx_done.
REQ-040 DATA1 with occupancy 0 -> SYNC and PID 8'h4B loaded (plus CRC when enabled), then EOP, then tx_done.

Source files
------------

// File: rtl/usb_tx_controller.sv
// USB packet transmit sequencer: SYNC, PID, optional payload, then EOP, driving an external bit timer and shift register.
// Optional feature: define TX_CRC16_EN to append crc_lo/crc_hi after the payload of DATA0/DATA1 packets.
module usb_tx_controller #(
  parameter int MAX_DATA_BYTES = 64,
  parameter int EOP_BITS       = 2
) (
  input  logic       clk,
  input  logic       n_rst,
  input  logic       tx_start,
  input  logic [3:0] tx_pid,
  input  logic [6:0] buffer_occupancy,
  input  logic [7:0] tx_packet_data,
  input  logic       bit_strobe,
  input  logic       one_byte_time,
`ifdef TX_CRC16_EN
  input  logic [7:0] crc_lo,
  input  logic [7:0] crc_hi,
`endif
  output logic       timer_enable,
  output logic       timer_clear,
  output logic       load_en,
  output logic [7:0] load_data,
  output logic       get_tx_data,
  output logic       eop,
  output logic       tx_busy,
  output logic       tx_done,
  output logic       tx_error
);

  localparam logic [3:0] S_IDLE      = 4'd0;
  localparam logic [3:0] S_LOAD_SYNC = 4'd1;
  localparam logic [3:0] S_SEND_SYNC = 4'd2;
  localparam logic [3:0] S_LOAD_PID  = 4'd3;
  localparam logic [3:0] S_SEND_PID  = 4'd4;
  localparam logic [3:0] S_LOAD_DATA = 4'd5;
  localparam logic [3:0] S_SEND_DATA = 4'd6;
  localparam logic [3:0] S_EOP       = 4'd7;
  localparam logic [3:0] S_EOP_IDLE  = 4'd8;
  localparam logic [3:0] S_LOAD_CRC1 = 4'd9;
  localparam logic [3:0] S_SEND_CRC1 = 4'd10;
  localparam logic [3:0] S_LOAD_CRC2 = 4'd11;
  localparam logic [3:0] S_SEND_CRC2 = 4'd12;

  localparam int EW = (EOP_BITS < 2) ? 1 : $clog2(EOP_BITS);

  logic [3:0]    state_q, state_d;
  logic [3:0]    pid_q, pid_d;
  logic [6:0]    rem_q, rem_d;
  logic [EW-1:0] eop_cnt_q, eop_cnt_d;
  logic          tx_done_q, tx_done_d;
  logic          tx_error_q, tx_error_d;

  logic          is_data_pid;
  logic          too_big;
  logic [3:0]    data_tail;

  assign is_data_pid = (pid_q == 4'b0011) || (pid_q == 4'b1011);
  assign too_big     = int'(buffer_occupancy) > MAX_DATA_BYTES;

  // Where a DATA packet goes once the payload is exhausted.
`ifdef TX_CRC16_EN
  assign data_tail = S_LOAD_CRC1;
`else
  assign data_tail = S_EOP;
`endif

  always_comb begin
    state_d    = state_q;
    pid_d      = pid_q;
    rem_d      = rem_q;
    eop_cnt_d  = eop_cnt_q;
    tx_done_d  = 1'b0;
    tx_error_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (tx_start) begin
          if (too_big) begin
            tx_error_d = 1'b1;
          end else begin
            pid_d     = tx_pid;
            rem_d     = buffer_occupancy;
            eop_cnt_d = '0;
            state_d   = S_LOAD_SYNC;
          end
        end
      end
      S_LOAD_SYNC: state_d = S_SEND_SYNC;
      S_SEND_SYNC: if (one_byte_time) state_d = S_LOAD_PID;
      S_LOAD_PID:  state_d = S_SEND_PID;
      S_SEND_PID: begin
        if (one_byte_time) begin
          if (!is_data_pid)       state_d = S_EOP;
          else if (rem_q != 7'd0) state_d = S_LOAD_DATA;
          else                    state_d = data_tail;
        end
      end
      S_LOAD_DATA: begin
        rem_d   = (rem_q != 7'd0) ? rem_q - 7'd1 : 7'd0;
        state_d = S_SEND_DATA;
      end
      S_SEND_DATA: begin
        if (one_byte_time) state_d = (rem_q != 7'd0) ? S_LOAD_DATA : data_tail;
      end
`ifdef TX_CRC16_EN
      S_LOAD_CRC1: state_d = S_SEND_CRC1;
      S_SEND_CRC1: if (one_byte_time) state_d = S_LOAD_CRC2;
      S_LOAD_CRC2: state_d = S_SEND_CRC2;
      S_SEND_CRC2: if (one_byte_time) state_d = S_EOP;
`endif
      S_EOP: begin
        if (bit_strobe) begin
          if (eop_cnt_q == EW'(EOP_BITS - 1)) begin
            eop_cnt_d = '0;
            state_d   = S_EOP_IDLE;
          end else begin
            eop_cnt_d = eop_cnt_q + 1'b1;
          end
        end
      end
      S_EOP_IDLE: begin
        if (bit_strobe) begin
          tx_done_d = 1'b1;
          state_d   = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q    <= S_IDLE;
      pid_q      <= '0;
      rem_q      <= '0;
      eop_cnt_q  <= '0;
      tx_done_q  <= 1'b0;
      tx_error_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pid_q      <= pid_d;
      rem_q      <= rem_d;
      eop_cnt_q  <= eop_cnt_d;
      tx_done_q  <= tx_done_d;
      tx_error_q <= tx_error_d;
    end
  end

  // Outputs decode from state only; payload and CRC bytes pass straight through during their load cycle.
  always_comb begin
    timer_clear  = 1'b0;
    timer_enable = 1'b0;
    load_en      = 1'b0;
    get_tx_data  = 1'b0;
    eop          = 1'b0;
    load_data    = 8'h00;
    case (state_q)
      S_IDLE:      timer_clear = 1'b1;
      S_LOAD_SYNC: begin load_en = 1'b1; load_data = 8'h80; end
      S_LOAD_PID:  begin load_en = 1'b1; load_data = {~pid_q, pid_q}; end
      S_LOAD_DATA: begin load_en = 1'b1; get_tx_data = 1'b1; load_data = tx_packet_data; end
`ifdef TX_CRC16_EN
      S_LOAD_CRC1: begin load_en = 1'b1; load_data = crc_lo; end
      S_LOAD_CRC2: begin load_en = 1'b1; load_data = crc_hi; end
      S_SEND_CRC1, S_SEND_CRC2: timer_enable = 1'b1;
`endif
      S_SEND_SYNC, S_SEND_PID, S_SEND_DATA, S_EOP_IDLE: timer_enable = 1'b1;
      S_EOP:       begin timer_enable = 1'b1; eop = 1'b1; end
      default: ;
    endcase
  end

  assign tx_busy  = (state_q != S_IDLE);
  assign tx_done  = tx_done_q;
  assign tx_error = tx_error_q;

endmodule

// File: tb/tb_usb_tx_controller.sv
// Bench for usb_tx_controller: table of packets driven against a behavioural bit timer, load bytes checked via scoreboard.
module tb_usb_tx_controller;
  localparam int MAXB = 64;
  localparam int EOPB = 2;

  logic       clk = 1'b0, n_rst = 1'b0, tx_start = 1'b0;
  logic [3:0] tx_pid = '0;
  logic [6:0] occ = '0;
  logic [7:0] tx_packet_data = '0;
  logic       bit_strobe = 1'b0, one_byte_time = 1'b0;
`ifdef TX_CRC16_EN
  logic [7:0] crc_lo = 8'h5A, crc_hi = 8'hC3;
`endif
  logic       timer_enable, timer_clear, load_en, get_tx_data, eop, tx_busy, tx_done, tx_error;
  logic [7:0] load_data;

  usb_tx_controller #(.MAX_DATA_BYTES(MAXB), .EOP_BITS(EOPB)) dut (
    .clk(clk), .n_rst(n_rst), .tx_start(tx_start), .tx_pid(tx_pid),
    .buffer_occupancy(occ), .tx_packet_data(tx_packet_data),
    .bit_strobe(bit_strobe), .one_byte_time(one_byte_time),
`ifdef TX_CRC16_EN
    .crc_lo(crc_lo), .crc_hi(crc_hi),
`endif
    .timer_enable(timer_enable), .timer_clear(timer_clear), .load_en(load_en),
    .load_data(load_data), .get_tx_data(get_tx_data), .eop(eop),
    .tx_busy(tx_busy), .tx_done(tx_done), .tx_error(tx_error)
  );

  always #5 clk = ~clk;

  // Behavioural bit timer: one bit every 2 clocks, byte after 8 bits.
  int tphase = 0, tbits = 0;
  always @(posedge clk) begin
    #1;
    if (!n_rst || timer_clear) begin
      tphase = 0; tbits = 0; bit_strobe = 1'b0; one_byte_time = 1'b0;
    end else if (timer_enable) begin
      tphase = tphase ^ 1;
      bit_strobe = (tphase == 1);
      one_byte_time = 1'b0;
      if (bit_strobe) begin
        tbits++;
        if (tbits == 8) begin tbits = 0; one_byte_time = 1'b1; end
      end
    end else begin
      bit_strobe = 1'b0; one_byte_time = 1'b0;
    end
  end

  int checks = 0, errors = 0;
  int n_load = 0, n_get = 0, eop_strb = 0, done_cnt = 0, err_cnt = 0;
  logic [7:0] exp_q[$];
  logic [7:0] tb_buf[$];
  logic [7:0] exp_b;

  always @(negedge clk) begin
    if (n_rst) begin
      if (load_en) begin
        n_load++;
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL load_data unexpected load got %02h", load_data);
        end else begin
          exp_b = exp_q.pop_front();
          if (load_data !== exp_b) begin
            errors++;
            $display("FAIL load_data got %02h expected %02h", load_data, exp_b);
          end
        end
      end
      if (get_tx_data) begin
        n_get++;
        if (tb_buf.size() > 0) tb_buf.delete(0);
        tx_packet_data = (tb_buf.size() > 0) ? tb_buf[0] : 8'h00;
      end
      if (eop && bit_strobe) eop_strb++;
      if (tx_done) done_cnt++;
      if (tx_error) err_cnt++;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, " timer_clear"}, 32'(timer_clear), 1);
    chk({tag, " timer_enable"}, 32'(timer_enable), 0);
    chk({tag, " load_en"}, 32'(load_en), 0);
    chk({tag, " get_tx_data"}, 32'(get_tx_data), 0);
    chk({tag, " eop"}, 32'(eop), 0);
    chk({tag, " tx_busy"}, 32'(tx_busy), 0);
    chk({tag, " tx_done"}, 32'(tx_done), 0);
    chk({tag, " tx_error"}, 32'(tx_error), 0);
    chk({tag, " load_data"}, 32'(load_data), 0);
  endtask

  typedef struct {
    logic [3:0] pid;
    logic [6:0] occ;
    logic [7:0] pbyte;
    logic [7:0] d0, d1, d2;
    bit         is_data;
    bit         err;
  } vec_t;

  function automatic logic [7:0] dbyte(input vec_t v, input int k);
    case (k)
      0: return v.d0;
      1: return v.d1;
      2: return v.d2;
      default: return v.d0 + 8'(k * 13);
    endcase
  endfunction

  task automatic start_pkt(input logic [3:0] pid, input logic [6:0] o);
    tick();
    tx_start = 1'b1; tx_pid = pid; occ = o;
    tick();
    tx_start = 1'b0; tx_pid = 4'($urandom); occ = 7'($urandom);
  endtask

  task automatic prep(input vec_t v);
    int nd;
    exp_q.delete(); tb_buf.delete();
    nd = v.is_data ? int'(v.occ) : 0;
    for (int k = 0; k < int'(v.occ); k++) tb_buf.push_back(dbyte(v, k));
    tx_packet_data = (tb_buf.size() > 0) ? tb_buf[0] : 8'h00;
    if (!v.err) begin
      exp_q.push_back(8'h80);
      exp_q.push_back(v.pbyte);
      for (int k = 0; k < nd; k++) exp_q.push_back(dbyte(v, k));
`ifdef TX_CRC16_EN
      if (v.is_data) begin exp_q.push_back(crc_lo); exp_q.push_back(crc_hi); end
`endif
    end
    n_load = 0; n_get = 0; done_cnt = 0; err_cnt = 0; eop_strb = 0;
  endtask

  task automatic run_packet(input vec_t v, input bit repulse, input string tag);
    int nexp_get, nexp_load;
    prep(v);
    nexp_get  = (v.is_data && !v.err) ? int'(v.occ) : 0;
    nexp_load = v.err ? 0 : 2 + nexp_get;
`ifdef TX_CRC16_EN
    if (v.is_data && !v.err) nexp_load += 2;
`endif
    start_pkt(v.pid, v.occ);
    if (v.err) begin
      chk({tag, " tx_error pulse"}, 32'(tx_error), 1);
      chk({tag, " tx_busy on error"}, 32'(tx_busy), 0);
      tick();
      chk({tag, " tx_error one cycle"}, 32'(tx_error), 0);
      repeat (20) tick();
      chk({tag, " no load_en"}, 32'(n_load), 0);
      chk({tag, " busy stays low"}, 32'(tx_busy), 0);
      chk({tag, " no tx_done"}, 32'(done_cnt), 0);
    end else begin
      chk({tag, " tx_busy"}, 32'(tx_busy), 1);
      if (repulse) begin
        for (int c = 0; c < 200 && n_load < 2; c++) tick();
        repeat (4) tick();
        tx_start = 1'b1; tx_pid = 4'b0011; occ = 7'd5;
        tick();
        tx_start = 1'b0;
      end
      for (int c = 0; c < 4000 && done_cnt == 0; c++) tick();
      repeat (30) tick();
      chk({tag, " tx_done count"}, 32'(done_cnt), 1);
      chk({tag, " tx_busy after"}, 32'(tx_busy), 0);
      chk({tag, " get_tx_data count"}, 32'(n_get), 32'(nexp_get));
      chk({tag, " load count"}, 32'(n_load), 32'(nexp_load));
      chk({tag, " loads pending"}, 32'(exp_q.size()), 0);
      chk({tag, " eop bit times"}, 32'(eop_strb), EOPB);
      chk({tag, " no tx_error"}, 32'(err_cnt), 0);
    end
  endtask

  vec_t vecs[7];

  initial begin
    vecs[0] = '{pid: 4'b0010, occ: 7'd0,  pbyte: 8'hD2, d0: 8'h00, d1: 8'h00, d2: 8'h00, is_data: 1'b0, err: 1'b0};
    vecs[1] = '{pid: 4'b0011, occ: 7'd3,  pbyte: 8'hC3, d0: 8'hA5, d1: 8'h3C, d2: 8'hFF, is_data: 1'b1, err: 1'b0};
    vecs[2] = '{pid: 4'b1011, occ: 7'd0,  pbyte: 8'h4B, d0: 8'h00, d1: 8'h00, d2: 8'h00, is_data: 1'b1, err: 1'b0};
    vecs[3] = '{pid: 4'b0011, occ: 7'd65, pbyte: 8'hC3, d0: 8'h11, d1: 8'h22, d2: 8'h33, is_data: 1'b1, err: 1'b1};
    vecs[4] = '{pid: 4'b1010, occ: 7'd5,  pbyte: 8'h5A, d0: 8'h77, d1: 8'h88, d2: 8'h99, is_data: 1'b0, err: 1'b0};
    vecs[5] = '{pid: 4'b1011, occ: 7'd64, pbyte: 8'h4B, d0: 8'h01, d1: 8'h80, d2: 8'h7E, is_data: 1'b1, err: 1'b0};
    vecs[6] = '{pid: 4'b0011, occ: 7'd1,  pbyte: 8'hC3, d0: 8'h00, d1: 8'h00, d2: 8'h00, is_data: 1'b1, err: 1'b0};

    #12;
    chk_reset_outs("reset");
    @(posedge clk); #2; n_rst = 1'b1;
    repeat (3) tick();

    for (int i = 0; i < 7; i++) run_packet(vecs[i], 1'b0, $sformatf("vec%0d", i));

    // Start a second request while the first is still in SEND_PID.
    run_packet(vecs[0], 1'b1, "repulse");

    // Abort mid-payload with an asynchronous reset.
    prep(vecs[1]);
    start_pkt(vecs[1].pid, vecs[1].occ);
    for (int c = 0; c < 400 && n_get < 2; c++) tick();
    repeat (3) tick();
    chk("abort in SEND_DATA", 32'(timer_enable), 1);
    #1 n_rst = 1'b0;
    #1 chk_reset_outs("async reset");
    exp_q.delete(); tb_buf.delete(); tx_packet_data = 8'h00;
    repeat (2) tick();
    n_rst = 1'b1;
    repeat (5) tick();
    chk("abort no tx_done", 32'(done_cnt), 0);
    chk("abort no tx_error", 32'(err_cnt), 0);
    run_packet(vecs[0], 1'b0, "post-reset ack");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
